// File: rtl/match_pkg.sv
// Shared types and constants for the match controller.
//   state_t    : game-flow states; encoding is exported on state_o
//   WIN_*      : winner output encodings
//   RALLY_MAX  : saturation point of the rally counter
package match_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [7:0] RALLY_MAX = 8'd255;

  function automatic logic [7:0] rally_inc(input logic [7:0] v);
    return (v == RALLY_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_evt_latch.sv
// Sticky per-frame event flag.
//   CLK, RESETn : clock, asynchronous active-low reset
//   i_set       : level input; any high cycle sets the flag
//   i_sof       : start-of-frame pulse; the flag is consumed and cleared
//   o_flag      : registered flag, valid as the frame's event when i_sof is high
// A set arriving in the i_sof cycle itself survives into the next frame.
module frame_evt_latch (
  input  logic CLK,
  input  logic RESETn,
  input  logic i_set,
  input  logic i_sof,
  output logic o_flag
);

  logic r_flag;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_flag <= 1'b0;
    end else if (i_sof) begin
      r_flag <= i_set;
    end else begin
      r_flag <= r_flag | i_set;
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/match_ctrl.sv
// Foosball game-flow controller.
//   CLK, RESETn     : clock, asynchronous active-low reset
//   startOfFrame    : one-cycle pulse per video frame; all frame actions happen here
//   start_key       : keypad level; rising edge starts a match / leaves OVER
//   collision, doubleball, goal_left, goal_right : per-pixel hit levels
//   ball_reset      : one-cycle pulse reloading the ball to centre
//   ball_enable     : ball may move (PLAY only)
//   serve_dir       : 0 serve left, 1 serve right
//   double_active   : bonus second ball live
//   score_p1/p2     : scores, rally_cnt : saturating collision count
//   winner          : 00 none, 01 player1, 10 player2
//   state_o         : current state encoding
module match_ctrl
  import match_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned PAUSE_FRAMES  = 120,
  parameter int unsigned DOUBLE_FRAMES = 600,
  parameter int unsigned TMR_W         = 10
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       startOfFrame,
  input  logic       start_key,
  input  logic       collision,
  input  logic       doubleball,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic       double_active,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [7:0] rally_cnt,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  localparam logic [3:0]       L_WIN    = 4'(WIN_SCORE);
  localparam logic [TMR_W-1:0] L_SERVE  = TMR_W'(SERVE_FRAMES);
  localparam logic [TMR_W-1:0] L_PAUSE  = TMR_W'(PAUSE_FRAMES);
  localparam logic [TMR_W-1:0] L_DOUBLE = TMR_W'(DOUBLE_FRAMES);

  logic w_col, w_db, w_gl, w_gr;

  frame_evt_latch u_col (.CLK(CLK), .RESETn(RESETn), .i_set(collision),  .i_sof(startOfFrame), .o_flag(w_col));
  frame_evt_latch u_db  (.CLK(CLK), .RESETn(RESETn), .i_set(doubleball), .i_sof(startOfFrame), .o_flag(w_db));
  frame_evt_latch u_gl  (.CLK(CLK), .RESETn(RESETn), .i_set(goal_left),  .i_sof(startOfFrame), .o_flag(w_gl));
  frame_evt_latch u_gr  (.CLK(CLK), .RESETn(RESETn), .i_set(goal_right), .i_sof(startOfFrame), .o_flag(w_gr));

  state_t           r_state, w_state_nx;
  logic [TMR_W-1:0] r_tmr, w_tmr_nx;
  logic [TMR_W-1:0] r_dbl_tmr, w_dbl_tmr_nx;
  logic             r_dbl, w_dbl_nx;
  logic [3:0]       r_sc1, w_sc1_nx;
  logic [3:0]       r_sc2, w_sc2_nx;
  logic [3:0]       w_sc_new;
  logic [7:0]       r_rally, w_rally_nx;
  logic [1:0]       r_win, w_win_nx;
  logic             r_dir, w_dir_nx;
  logic             r_brst, w_brst_nx;
  logic             r_key_prev;
  logic             w_start_edge;

  assign w_start_edge = start_key & ~r_key_prev;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_dbl_tmr  <= '0;
      r_dbl      <= 1'b0;
      r_sc1      <= '0;
      r_sc2      <= '0;
      r_rally    <= '0;
      r_win      <= WIN_NONE;
      r_dir      <= 1'b0;
      r_brst     <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tmr      <= w_tmr_nx;
      r_dbl_tmr  <= w_dbl_tmr_nx;
      r_dbl      <= w_dbl_nx;
      r_sc1      <= w_sc1_nx;
      r_sc2      <= w_sc2_nx;
      r_rally    <= w_rally_nx;
      r_win      <= w_win_nx;
      r_dir      <= w_dir_nx;
      r_brst     <= w_brst_nx;
      r_key_prev <= start_key;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_tmr_nx     = r_tmr;
    w_dbl_tmr_nx = r_dbl_tmr;
    w_dbl_nx     = r_dbl;
    w_sc1_nx     = r_sc1;
    w_sc2_nx     = r_sc2;
    w_sc_new     = '0;
    w_rally_nx   = r_rally;
    w_win_nx     = r_win;
    w_dir_nx     = r_dir;
    w_brst_nx    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_sc1_nx   = '0;
          w_sc2_nx   = '0;
          w_rally_nx = '0;
          w_win_nx   = WIN_NONE;
          w_dbl_nx   = 1'b0;
          w_brst_nx  = 1'b1;
          w_tmr_nx   = L_SERVE;
          w_state_nx = SERVE;
        end
      end

      SERVE: begin
        if (startOfFrame) begin
          if (r_tmr == '0) w_state_nx = PLAY;
          else             w_tmr_nx   = r_tmr - 1'b1;
        end
      end

      PLAY: begin
        if (startOfFrame) begin
          // Bonus ageing uses the pre-frame active flag, so a doubleball
          // event while active is ignored even on the expiry frame.
          if (r_dbl) begin
            if (r_dbl_tmr == '0) w_dbl_nx     = 1'b0;
            else                 w_dbl_tmr_nx = r_dbl_tmr - 1'b1;
          end
          if (w_gl || w_gr) begin
            w_dbl_nx = 1'b0;
            if (w_gl) begin
              w_sc_new = r_sc2 + 4'd1;
              w_sc2_nx = w_sc_new;
              w_dir_nx = 1'b0;
            end else begin
              w_sc_new = r_sc1 + 4'd1;
              w_sc1_nx = w_sc_new;
              w_dir_nx = 1'b1;
            end
            if (w_sc_new == L_WIN) begin
              w_win_nx   = w_gl ? WIN_P2 : WIN_P1;
              w_state_nx = OVER;
            end else begin
              w_tmr_nx   = L_PAUSE;
              w_state_nx = PAUSE;
            end
          end else begin
            if (w_db && !r_dbl) begin
              w_dbl_nx     = 1'b1;
              w_dbl_tmr_nx = L_DOUBLE;
            end
            if (w_col) w_rally_nx = rally_inc(r_rally);
          end
        end
      end

      PAUSE: begin
        if (startOfFrame) begin
          if (r_tmr == '0) begin
            w_rally_nx = '0;
            w_brst_nx  = 1'b1;
            w_tmr_nx   = L_SERVE;
            w_state_nx = SERVE;
          end else begin
            w_tmr_nx = r_tmr - 1'b1;
          end
        end
      end

      OVER: begin
        if (w_start_edge) w_state_nx = IDLE;
      end

      default: w_state_nx = IDLE;
    endcase
  end

  assign ball_reset    = r_brst;
  assign ball_enable   = (r_state == PLAY);
  assign serve_dir     = r_dir;
  assign double_active = r_dbl;
  assign score_p1      = r_sc1;
  assign score_p2      = r_sc2;
  assign rally_cnt     = r_rally;
  assign winner        = r_win;
  assign state_o       = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
module tb_match_ctrl;

  localparam int WIN = 2;
  localparam int SRV = 3;
  localparam int PAU = 2;
  localparam int DBL = 4;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic startOfFrame = 1'b0;
  logic start_key = 1'b0;
  logic collision = 1'b0;
  logic doubleball = 1'b0;
  logic goal_left = 1'b0;
  logic goal_right = 1'b0;

  logic       ball_reset, ball_enable, serve_dir, double_active;
  logic [3:0] score_p1, score_p2;
  logic [7:0] rally_cnt;
  logic [1:0] winner;
  logic [2:0] state_o;

  match_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SRV),
    .PAUSE_FRAMES (PAU),
    .DOUBLE_FRAMES(DBL),
    .TMR_W        (4)
  ) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .startOfFrame (startOfFrame),
    .start_key    (start_key),
    .collision    (collision),
    .doubleball   (doubleball),
    .goal_left    (goal_left),
    .goal_right   (goal_right),
    .ball_reset   (ball_reset),
    .ball_enable  (ball_enable),
    .serve_dir    (serve_dir),
    .double_active(double_active),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .rally_cnt    (rally_cnt),
    .winner       (winner),
    .state_o      (state_o)
  );

  always #5 CLK = ~CLK;

  logic [24:0] dut_vec;
  assign dut_vec = {state_o, ball_enable, serve_dir, double_active,
                    score_p1, score_p2, rally_cnt, winner, ball_reset};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game phase (0 idle,1 serve,2 play,3 pause,4 over),
  // frames still to spend in the phase, and bonus frames remaining.
  int   m_phase, m_left, m_s1, m_s2, m_rally, m_win, m_dbl_left;
  bit   m_dir, m_breset;
  logic [3:0] pend;  // {gl, gr, db, col} seen since the last frame tick

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_rally = 0;
    m_win = 0; m_dbl_left = 0; m_dir = 1'b0; m_breset = 1'b0;
  endfunction

  function automatic void model_start();
    if (m_phase == 0) begin
      m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0; m_dbl_left = 0;
      m_left = SRV + 1; m_phase = 1; m_breset = 1'b1;
    end else if (m_phase == 4) begin
      m_phase = 0;
    end
  endfunction

  function automatic void model_tick(input logic [3:0] ev);
    bit was_active;
    m_breset = 1'b0;
    case (m_phase)
      1: begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: begin
        was_active = (m_dbl_left > 0);
        if (was_active) m_dbl_left--;
        if (ev[3] || ev[2]) begin
          if (ev[3]) begin m_s2++; m_dir = 1'b0; end
          else       begin m_s1++; m_dir = 1'b1; end
          m_dbl_left = 0;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_win = ev[3] ? 2 : 1;
            m_phase = 4;
          end else begin
            m_left = PAU + 1;
            m_phase = 3;
          end
        end else begin
          if (ev[1] && !was_active) m_dbl_left = DBL + 1;
          if (ev[0] && m_rally < 255) m_rally++;
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          m_rally = 0; m_breset = 1'b1; m_left = SRV + 1; m_phase = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [24:0] exp_vec();
    return {3'(m_phase), (m_phase == 2), m_dir, (m_dbl_left > 0),
            4'(m_s1), 4'(m_s2), 8'(m_rally), 2'(m_win), m_breset};
  endfunction

  task automatic drive_ev(input logic [3:0] ev);
    {goal_left, goal_right, doubleball, collision} = ev;
  endtask

  // Frame body: ev held for the first `hold` cycles, optional start pulse.
  task automatic frame_body(input logic [3:0] ev, input int hold, input bit startp);
    int len;
    len = $urandom_range(6, 9);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      startOfFrame = 1'b0;
      drive_ev((i < hold) ? ev : 4'b0000);
      start_key = startp && (i == 2 || i == 3);
      @(posedge CLK);
      m_breset = 1'b0;
      if (startp && i == 2) model_start();
    end
    if (hold > 0) pend = pend | ev;
  endtask

  // Frame tick: sofev is driven during the startOfFrame cycle itself.
  task automatic frame_tick(input logic [3:0] sofev);
    @(negedge CLK);
    startOfFrame = 1'b1;
    start_key = 1'b0;
    drive_ev(sofev);
    @(posedge CLK);
    model_tick(pend);
    pend = sofev;
    #1;
  endtask

  function automatic logic [3:0] noise();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    model_reset();
    pend = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive_ev(noise());
      startOfFrame = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_hold: got %h expected %h", dut_vec, exp_vec());
      end
    end
    @(negedge CLK);
    drive_ev(4'b0000);
    startOfFrame = 1'b0;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_serve();
    @(negedge CLK);
    start_key = 1'b1;
    @(posedge CLK);
    m_breset = 1'b0;
    model_start();
    #1;
    n_cmp++;
    if (dut_vec !== exp_vec() || ball_reset !== 1'b1 || state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL serve_start: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge CLK);
    start_key = 1'b0;
    @(posedge CLK);
    m_breset = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== exp_vec() || ball_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL serve_pulse_width: got %h expected %h", dut_vec, exp_vec());
    end
    for (int t = 1; t <= 4; t++) begin
      if (t > 1) frame_body(noise(), $urandom_range(1, 4), 1'b0);
      frame_tick(4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL serve_tick%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (state_o !== 3'd2 || ball_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL serve_to_play: got state %0d en %b expected state 2 en 1", state_o, ball_enable);
    end
  endtask

  task automatic test_rally_saturate();
    for (int f = 0; f < 300; f++) begin
      frame_body(4'b0001, $urandom_range(1, 5), 1'b0);
      frame_tick(4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL rally_frame%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (rally_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL rally_saturate: got %0d expected 255", rally_cnt);
    end
  endtask

  task automatic test_double_expire();
    logic [3:0] ev;
    for (int f = 0; f < 6; f++) begin
      ev = (f == 0) ? 4'b0011 : (f == 2) ? 4'b0010 : 4'b0001;
      frame_body(ev, $urandom_range(1, 4), 1'b0);
      frame_tick(4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL double_frame%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
      n_cmp++;
      if (double_active !== (f < 5)) begin
        n_bad++;
        $display("FAIL double_life%0d: got %b expected %b", f, double_active, (f < 5));
      end
    end
  endtask

  task automatic test_goal_hold();
    frame_body(4'b0010, 2, 1'b0);
    frame_tick(4'b0000);
    frame_body(4'b0000, 0, 1'b0);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || double_active !== 1'b1) begin
      n_bad++;
      $display("FAIL goal_pre_double: got %h expected %h", dut_vec, exp_vec());
    end
    frame_body(4'b0100, 5, 1'b0);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || score_p1 !== 4'd1 || serve_dir !== 1'b1 ||
        state_o !== 3'd3 || double_active !== 1'b0) begin
      n_bad++;
      $display("FAIL goal_right_once: got %h expected %h", dut_vec, exp_vec());
    end
    for (int k = 0; k <= PAU; k++) begin
      frame_body(noise(), $urandom_range(1, 4), 1'b0);
      frame_tick(4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL pause_frame%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (ball_reset !== 1'b1 || rally_cnt !== 8'd0 || state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL pause_exit: got brst %b rally %0d state %0d expected 1 0 1",
               ball_reset, rally_cnt, state_o);
    end
    for (int t = 0; t <= SRV; t++) begin
      frame_body(noise(), $urandom_range(1, 4), 1'b0);
      frame_tick(4'b0000);
    end
    n_cmp++;
    if (dut_vec !== exp_vec() || state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL reserve_play: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_both_goals();
    frame_body(4'b1100, $urandom_range(1, 5), 1'b0);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || score_p2 !== 4'd1 || score_p1 !== 4'd1 || serve_dir !== 1'b0) begin
      n_bad++;
      $display("FAIL both_goals: got %h expected %h", dut_vec, exp_vec());
    end
    for (int t = 0; t <= PAU + SRV + 1; t++) begin
      frame_body(noise(), $urandom_range(1, 4), 1'b0);
      frame_tick(4'b0000);
    end
    n_cmp++;
    if (dut_vec !== exp_vec() || state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL both_goals_replay: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_winner();
    frame_body(4'b1000, $urandom_range(1, 5), 1'b0);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || winner !== 2'b10 || state_o !== 3'd4 || score_p2 !== 4'd2) begin
      n_bad++;
      $display("FAIL winner_p2: got %h expected %h", dut_vec, exp_vec());
    end
    for (int f = 0; f < 3; f++) begin
      frame_body(noise(), $urandom_range(1, 5), 1'b0);
      frame_tick(noise());
      n_cmp++;
      if (dut_vec !== exp_vec() || score_p2 !== 4'd2) begin
        n_bad++;
        $display("FAIL over_frozen%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
    frame_body(4'b0000, 0, 1'b1);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL over_to_idle: got %h expected %h", dut_vec, exp_vec());
    end
    frame_body(4'b0000, 0, 1'b1);
    frame_tick(4'b0000);
    n_cmp++;
    if (dut_vec !== exp_vec() || score_p1 !== 4'd0 || score_p2 !== 4'd0 || state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL restart_clear: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    bit startp;
    for (int f = 0; f < 250; f++) begin
      ev[3] = ($urandom_range(0, 11) == 0);
      ev[2] = ($urandom_range(0, 11) == 0);
      ev[1] = ($urandom_range(0, 7) == 0);
      ev[0] = 1'($urandom_range(0, 1));
      if (m_phase == 0 || m_phase == 4) startp = ($urandom_range(0, 2) == 0);
      else                              startp = ($urandom_range(0, 19) == 0);
      frame_body(ev, $urandom_range(1, 5), startp);
      frame_tick(($urandom_range(0, 7) == 0) ? noise() : 4'b0000);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_frame%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 30 && !(m_phase == 2 && m_rally > 0); i++) begin
      frame_body(4'b0001, 2, (m_phase == 0 || m_phase == 4));
      frame_tick(4'b0000);
    end
    n_cmp++;
    if (state_o !== 3'd2 || dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL reach_play: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge CLK);
    drive_ev(4'b0000);
    #2;
    RESETn = 1'b0;
    model_reset();
    pend = '0;
    #1;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_mid_play: got %h expected %h", dut_vec, exp_vec());
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally_saturate();
    test_double_expire();
    test_goal_hold();
    test_both_goals();
    test_winner();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
